// File: rtl/ntsc_zbt_pkg.sv
// ---------------------------------------------------------------------------
// ntsc_zbt_pkg
//
// Shared definitions for the NTSC-to-ZBT packer:
//   - default 720x486 NTSC geometry (two 243-line fields, 12 blanking lines)
//   - packer FSM state enum
//   - compose_addr : builds {buf, row, word} from its parts for any widths
//   - mirror_col   : maps an incoming column onto its horizontally flipped one
// ---------------------------------------------------------------------------
package ntsc_zbt_pkg;

   localparam int NTSC_ACTIVE_W        = 720;
   localparam int NTSC_LINES_PER_FIELD = 243;
   localparam int NTSC_FRAME_LINES     = 2 * NTSC_LINES_PER_FIELD;
   localparam int NTSC_SKIP_LINES      = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SKIP   = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } pack_state_t;

   // Packs buffer select, row and word index into one flat address. Each
   // field is masked to its width so an oversized row/word cannot spill
   // into the neighbouring field. The caller truncates to its ADDR_W.
   function automatic logic [63:0] compose_addr(input logic        buf_sel,
                                                input logic [31:0] row,
                                                input logic [31:0] word,
                                                input int          row_aw,
                                                input int          word_aw);
      logic [63:0] row_f;
      logic [63:0] word_f;
      logic [63:0] buf_f;
      row_f  = {32'd0, row}  & ((64'd1 << row_aw)  - 64'd1);
      word_f = {32'd0, word} & ((64'd1 << word_aw) - 64'd1);
      buf_f  = {63'd0, buf_sel} << (row_aw + word_aw);
      return buf_f | (row_f << word_aw) | word_f;
   endfunction

   // Column index as seen after a horizontal flip of an active_w wide line.
   function automatic int mirror_col(input int col, input int active_w);
      return active_w - 1 - col;
   endfunction

endpackage

// File: rtl/zbt_wr_fifo.sv
// ---------------------------------------------------------------------------
// zbt_wr_fifo
//
// Small word+address FIFO sitting between the pixel packer and the ZBT write
// arbiter. A push while full is only accepted when the head pops in the same
// cycle; otherwise the new entry is discarded and 'drop' pulses so the parent
// can count the loss.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (flushes contents)
//   push, push_data  entry offered by the packer this cycle
//   full           FIFO holds DEPTH entries
//   drop           push was refused (full and no pop)
//   out_valid      head entry present
//   out_ready      consumer takes the head this cycle
//   out_data       head entry, zero while empty
// ---------------------------------------------------------------------------
module zbt_wr_fifo #(
   parameter int DATA_W = 55,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   output logic              drop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              pop;
   logic              push_ok;

   // Handshake decode: a full FIFO still accepts a push when the head leaves
   // in the same cycle, which keeps a depth-2 buffer at full throughput.
   always_comb begin
      out_valid = (count != '0);
      full      = (count == CNT_W'(DEPTH));
      pop       = out_valid && out_ready;
      push_ok   = push && (!full || pop);
      drop      = push && full && !pop;
      out_data  = out_valid ? mem[rd_ptr] : '0;
   end

   // Storage, pointers and occupancy. Storage is cleared on reset so the
   // head never shows stale data from before a reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ntsc_zbt_packer.sv
// ---------------------------------------------------------------------------
// ntsc_zbt_packer
//
// Takes a decoded, clk-synchronous luminance stream, skips the blanking lines
// after each start-of-field, crops each line to ACTIVE_W pixels, optionally
// mirrors it, and packs PPW pixels into one ZBT word. Completed words go
// through a small FIFO to a valid/ready write port. Two frame buffers are
// used alternately; disp_buf always names the one not being written.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   sof, field     start-of-field pulse and its field parity (0 = even)
//   sol            start-of-line pulse
//   pix_valid, pix_data  incoming pixel
//   wr_valid, wr_ready   write request handshake
//   wr_addr        {buf, row, word}
//   wr_data        packed pixels, first stored column in the MSBs
//   wr_buf         buffer being written
//   disp_buf       buffer stable for display (~wr_buf)
//   frame_done     pulses in the sof cycle that swaps buffers
//   ovf_count      saturating count of words lost to a full FIFO
// ---------------------------------------------------------------------------
module ntsc_zbt_packer
   import ntsc_zbt_pkg::*;
#(
   parameter  int PIX_W           = 8,
   parameter  int PPW             = 4,
   parameter  int WORD_W          = 36,
   parameter  int ACTIVE_W        = NTSC_ACTIVE_W,
   parameter  int LINES_PER_FIELD = NTSC_LINES_PER_FIELD,
   parameter  int SKIP_LINES      = NTSC_SKIP_LINES,
   parameter  int INTERLACED      = 1,
   parameter  int MIRROR          = 1,
   parameter  int ROW_AW          = 9,
   parameter  int WORD_AW         = 9,
   parameter  int FIFO_DEPTH      = 2,
   localparam int ADDR_W          = 1 + ROW_AW + WORD_AW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sof,
   input  logic              field,
   input  logic              sol,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_buf,
   output logic              disp_buf,
   output logic              frame_done,
   output logic [7:0]        ovf_count
);

   localparam int PACK_W = PPW * PIX_W;
   localparam int COL_W  = $clog2(ACTIVE_W + 1);
   localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int LINE_W = ROW_AW;
   localparam int ENTRY_W = ADDR_W + WORD_W;

   pack_state_t        state;
   pack_state_t        state_next;
   logic               field_q;
   logic [LINE_W-1:0]  line_cnt;
   logic [LINE_W-1:0]  line;
   logic [COL_W-1:0]   col;
   logic [LANE_W-1:0]  lane;
   logic [PACK_W-1:0]  pack_q;
   logic [PACK_W-1:0]  pack_next;
   logic               wr_buf_q;
   logic [7:0]         ovf_q;

   logic               swap;
   logic               pix_take;
   logic               lane_last;
   logic               push;
   logic [LANE_W-1:0]  slot;
   logic [ROW_AW-1:0]  row;
   logic [WORD_AW-1:0] word_idx;
   logic [ADDR_W-1:0]  push_addr;
   logic [WORD_W-1:0]  push_word;
   logic               fifo_full;
   logic               fifo_drop;
   logic [ENTRY_W-1:0] fifo_out;

   // Field boundary and pixel qualification. sof and sol take priority over
   // a pixel arriving in the same cycle, and pixels beyond the stored width
   // are simply ignored. A word is complete when its last lane is filled.
   always_comb begin
      swap      = sof && ((INTERLACED == 0) || !field);
      pix_take  = (state == ACTIVE) && pix_valid && !sof && !sol &&
                  (col < COL_W'(ACTIVE_W));
      lane_last = (lane == LANE_W'(PPW - 1));
      push      = pix_take && lane_last;
   end

   // Placement of the current pixel. When mirrored, the lanes fill from the
   // top so lane 0 of the stored word still holds the leftmost stored column,
   // and the word index counts down from the right edge of the line.
   always_comb begin
      int base;
      slot = (MIRROR != 0) ? (LANE_W'(PPW - 1) - lane) : lane;
      base = (PPW - 1 - int'(slot)) * PIX_W;
      pack_next = pack_q;
      pack_next[base +: PIX_W] = pix_data;
      if (MIRROR != 0) begin
         word_idx = WORD_AW'(mirror_col(int'(col), ACTIVE_W) / PPW);
      end else begin
         word_idx = WORD_AW'(int'(col) / PPW);
      end
   end

   // Row address: interleave the two fields line by line when interlaced so
   // a full frame ends up in progressive order in memory.
   always_comb begin
      if (INTERLACED != 0) begin
         row = {line[ROW_AW-2:0], field_q};
      end else begin
         row = line;
      end
      push_addr = ADDR_W'(compose_addr(wr_buf_q, 32'(row), 32'(word_idx),
                                       ROW_AW, WORD_AW));
      push_word = WORD_W'(pack_next);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state. A sof restarts the field from any state; otherwise the
   // line counters decide when blanking ends and when the field is full.
   always_comb begin
      state_next = state;
      if (sof) begin
         state_next = SKIP;
      end else begin
         case (state)
            SKIP: begin
               if (sol && (line_cnt == LINE_W'(SKIP_LINES))) begin
                  state_next = ACTIVE;
               end
            end
            ACTIVE: begin
               if (sol && (line == LINE_W'(LINES_PER_FIELD - 1))) begin
                  state_next = DONE;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   // Line, column and lane tracking plus the packing register. Resetting
   // col/lane on sof or sol is what discards a partially packed word.
   // The sol that arrives once SKIP_LINES blanking lines have been counted
   // opens active line 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         field_q  <= 1'b0;
         line_cnt <= '0;
         line     <= '0;
         col      <= '0;
         lane     <= '0;
         pack_q   <= '0;
      end else if (sof) begin
         field_q  <= field;
         line_cnt <= '0;
         line     <= '0;
         col      <= '0;
         lane     <= '0;
      end else begin
         case (state)
            SKIP: begin
               if (sol) begin
                  if (line_cnt == LINE_W'(SKIP_LINES)) begin
                     line <= '0;
                     col  <= '0;
                     lane <= '0;
                  end else begin
                     line_cnt <= line_cnt + 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (sol) begin
                  line <= line + 1'b1;
                  col  <= '0;
                  lane <= '0;
               end else if (pix_take) begin
                  pack_q <= pack_next;
                  col    <= col + 1'b1;
                  lane   <= lane_last ? '0 : lane + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Buffer ownership and overflow statistics. The buffer bit is captured
   // into each address at push time, so words already queued keep the
   // buffer they were packed for even if a swap follows.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_buf_q <= 1'b0;
         ovf_q    <= '0;
      end else begin
         if (swap) begin
            wr_buf_q <= ~wr_buf_q;
         end
         if (fifo_drop && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 1'b1;
         end
      end
   end

   zbt_wr_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data ({push_addr, push_word}),
      .full      (fifo_full),
      .drop      (fifo_drop),
      .out_valid (wr_valid),
      .out_ready (wr_ready),
      .out_data  (fifo_out)
   );

   // Output mapping.
   always_comb begin
      wr_addr    = fifo_out[ENTRY_W-1:WORD_W];
      wr_data    = fifo_out[WORD_W-1:0];
      wr_buf     = wr_buf_q;
      disp_buf   = ~wr_buf_q;
      frame_done = swap;
      ovf_count  = ovf_q;
   end

endmodule
